// File: rtl/acq_cmd_scheduler.sv
// rtl/acq_cmd_scheduler.sv - UART-commanded acquire sequencer driving active-low capture strobes
// Decodes 8N1 command bytes, arms a wave/FIR capture on a fresh wavenum, holds one pending command.
module acq_cmd_scheduler #(
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned WINDOW       = 36050,
    parameter logic [7:0]  CMD_WAVE     = 8'h77,
    parameter logic [7:0]  CMD_FIR      = 8'h69
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx,
    input  logic [15:0] wavenum,
    output logic        acquireWave,
    output logic        acquireFIR,
    output logic        busy,
    output logic [7:0]  cmd_char,
    output logic        cmd_valid,
    output logic [15:0] lastwavenum,
    output logic        err_framing,
    output logic        timeout,
    output logic        dropped
);

    localparam logic [15:0] FIRST_WAIT = 16'(CLKS_PER_BIT / 2 + CLKS_PER_BIT - 1);
    localparam logic [15:0] BIT_WAIT   = 16'(CLKS_PER_BIT - 1);
    localparam logic [18:0] WIN_LAST   = 19'(WINDOW - 1);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_ACQ, S_RELEASE} state_t;

    logic        rx_active_q, rx_active_d;
    logic [15:0] rx_wait_q, rx_wait_d;
    logic [3:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [7:0]  cmd_char_q, cmd_char_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic        err_framing_q, err_framing_d;

    state_t      state_q, state_d;
    logic [18:0] cnt_q, cnt_d;
    logic        kind_fir_q, kind_fir_d;
    logic        acq_seen_q, acq_seen_d;
    logic        pend_valid_q, pend_valid_d;
    logic        pend_fir_q, pend_fir_d;
    logic [15:0] lastwavenum_q, lastwavenum_d;
    logic        acq_wave_n_q, acq_wave_n_d;
    logic        acq_fir_n_q, acq_fir_n_d;

    logic        is_cmd;
    logic        cmd_is_fir;
    logic        timeout_pulse;
    logic        dropped_pulse;

    // Receiver: a down-counter paces the mid-bit samples; bit index 8 is the stop bit.
    always_comb begin
        rx_active_d   = rx_active_q;
        rx_wait_d     = rx_wait_q;
        rx_bit_d      = rx_bit_q;
        rx_shift_d    = rx_shift_q;
        cmd_char_d    = cmd_char_q;
        cmd_valid_d   = 1'b0;
        err_framing_d = 1'b0;
        if (!rx_active_q) begin
            if (!uart_rx) begin
                rx_active_d = 1'b1;
                rx_wait_d   = FIRST_WAIT;
                rx_bit_d    = 4'd0;
            end
        end else if (rx_wait_q != 16'd0) begin
            rx_wait_d = rx_wait_q - 16'd1;
        end else begin
            rx_wait_d = BIT_WAIT;
            if (rx_bit_q == 4'd8) begin
                rx_active_d = 1'b0;
                if (uart_rx) begin
                    cmd_char_d  = rx_shift_q;
                    cmd_valid_d = 1'b1;
                end else begin
                    err_framing_d = 1'b1;
                end
            end else begin
                rx_shift_d = {uart_rx, rx_shift_q[7:1]};
                rx_bit_d   = rx_bit_q + 4'd1;
            end
        end
    end

    assign is_cmd     = cmd_valid_q && ((cmd_char_q == CMD_WAVE) || (cmd_char_q == CMD_FIR));
    assign cmd_is_fir = (cmd_char_q == CMD_FIR);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        kind_fir_d    = kind_fir_q;
        acq_seen_d    = acq_seen_q;
        pend_valid_d  = pend_valid_q;
        pend_fir_d    = pend_fir_q;
        lastwavenum_d = lastwavenum_q;
        timeout_pulse = 1'b0;
        dropped_pulse = 1'b0;

        // Commands seen while busy (including RELEASE) land in the pending slot first.
        if (is_cmd && (state_q != S_IDLE)) begin
            pend_valid_d  = 1'b1;
            pend_fir_d    = cmd_is_fir;
            dropped_pulse = pend_valid_q;
        end

        case (state_q)
            S_IDLE: begin
                if (is_cmd) begin
                    state_d    = S_ARM;
                    kind_fir_d = cmd_is_fir;
                    cnt_d      = 19'd0;
                    acq_seen_d = 1'b0;
                end
            end
            S_ARM: begin
                cnt_d = cnt_q + 19'd1;
                if (cnt_q == WIN_LAST) begin
                    timeout_pulse = 1'b1;
                    state_d       = S_RELEASE;
                end else if (wavenum != lastwavenum_q) begin
                    state_d    = S_ACQ;
                    acq_seen_d = 1'b1;
                end
            end
            S_ACQ: begin
                cnt_d = cnt_q + 19'd1;
                if (cnt_q == WIN_LAST) begin
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (acq_seen_q) begin
                    lastwavenum_d = wavenum;
                end
                if (pend_valid_d) begin
                    state_d      = S_ARM;
                    kind_fir_d   = pend_fir_d;
                    pend_valid_d = 1'b0;
                    cnt_d        = 19'd0;
                    acq_seen_d   = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Strobes lag the state by one cycle, so they fall after ACQ entry and clear after RELEASE.
        acq_wave_n_d = !((state_q == S_ACQ) && !kind_fir_q);
        acq_fir_n_d  = !((state_q == S_ACQ) && kind_fir_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_active_q   <= 1'b0;
            rx_wait_q     <= 16'd0;
            rx_bit_q      <= 4'd0;
            rx_shift_q    <= 8'd0;
            cmd_char_q    <= 8'd0;
            cmd_valid_q   <= 1'b0;
            err_framing_q <= 1'b0;
            state_q       <= S_IDLE;
            cnt_q         <= 19'd0;
            kind_fir_q    <= 1'b0;
            acq_seen_q    <= 1'b0;
            pend_valid_q  <= 1'b0;
            pend_fir_q    <= 1'b0;
            lastwavenum_q <= 16'd0;
            acq_wave_n_q  <= 1'b1;
            acq_fir_n_q   <= 1'b1;
        end else begin
            rx_active_q   <= rx_active_d;
            rx_wait_q     <= rx_wait_d;
            rx_bit_q      <= rx_bit_d;
            rx_shift_q    <= rx_shift_d;
            cmd_char_q    <= cmd_char_d;
            cmd_valid_q   <= cmd_valid_d;
            err_framing_q <= err_framing_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            kind_fir_q    <= kind_fir_d;
            acq_seen_q    <= acq_seen_d;
            pend_valid_q  <= pend_valid_d;
            pend_fir_q    <= pend_fir_d;
            lastwavenum_q <= lastwavenum_d;
            acq_wave_n_q  <= acq_wave_n_d;
            acq_fir_n_q   <= acq_fir_n_d;
        end
    end

    assign acquireWave = acq_wave_n_q;
    assign acquireFIR  = acq_fir_n_q;
    assign busy        = (state_q != S_IDLE);
    assign cmd_char    = cmd_char_q;
    assign cmd_valid   = cmd_valid_q;
    assign lastwavenum = lastwavenum_q;
    assign err_framing = err_framing_q;
    assign timeout     = timeout_pulse;
    assign dropped     = dropped_pulse;

endmodule

// File: doc/acq_cmd_scheduler.md
Name: acq_cmd_scheduler

Overview:
Replaces the ad-hoc UART-triggered acquire switch with a sequenced controller. It decodes single-byte UART commands and arms a waveform or FIR capture. The capture starts only once a new wavenum arrives, and the block drives the active-low acquireWave/acquireFIR strobes for a bounded window. It sits between the UART RX pin and the ADC capture/FIR datapath, and queues one command received while a capture is in progress.

Parameters:
CLKS_PER_BIT, 1, clk cycles per UART bit (>=1); the existing design runs at 1 MHz with one bit per clock
WINDOW, 36050, cycles from ARM entry to forced release (19-bit counter)
CMD_WAVE, 8'h77, command byte 'w' selecting waveform capture
CMD_FIR, 8'h69, command byte 'i' selecting FIR capture

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
uart_rx  in  1  UART receive line, idle high, 8N1, LSB first
wavenum  in  16  current waveform sequence number from the capture path
acquireWave  out  1  active-low waveform capture enable
acquireFIR  out  1  active-low FIR capture enable
busy  out  1  high in any state other than IDLE
cmd_char  out  8  last correctly framed byte
cmd_valid  out  1  one-cycle pulse when cmd_char updates
lastwavenum  out  16  wavenum latched at the last release
err_framing  out  1  one-cycle pulse when the stop bit is sampled 0
timeout  out  1  one-cycle pulse when the window expires in ARM
dropped  out  1  one-cycle pulse when a pending command is overwritten

Behaviour:
- Reset (async, immediate) sets: acquireWave=1, acquireFIR=1, busy=0, cmd_char=0, cmd_valid=0, lastwavenum=0, all pulses 0, pending empty, FSM=IDLE, receiver idle. Reset mid-frame or mid-capture aborts with no pulses.
- Receiver:
  - Start is detected on the first cycle uart_rx==0 while the receiver is idle (cycle D).
  - Data bit k (k=1..8) is sampled at D + CLKS_PER_BIT/2 + k*CLKS_PER_BIT (integer divide). The stop bit is sampled at k=9.
  - Stop==1: cmd_char updates and cmd_valid pulses on the cycle after the stop sample.
  - Stop==0: err_framing pulses on the same cycle after the stop sample; cmd_char is unchanged and cmd_valid does not pulse.
  - The receiver re-arms the cycle after the stop sample. It runs in every FSM state.
- Command acceptance: only bytes equal to CMD_WAVE or CMD_FIR are commands. Other bytes pulse cmd_valid only.
- FSM states: IDLE, ARM, ACQ, RELEASE.
  - IDLE: a command with cmd_valid moves to ARM, stores the kind, and clears the window counter.
  - ARM:
    - Window counter increments each cycle.
    - If wavenum != lastwavenum, go to ACQ next cycle.
    - If the counter reaches WINDOW-1 first, pulse timeout and go to RELEASE without asserting a strobe.
  - ACQ:
    - Drive the strobe selected by the stored kind to 0; the other stays 1.
    - The counter continues. At WINDOW-1, go to RELEASE.
  - RELEASE (1 cycle):
    - Both strobes go to 1.
    - lastwavenum<=wavenum, only if ACQ was reached.
    - If pending is valid, go to ARM with the pending kind, clear pending, and reset the counter. Otherwise go to IDLE.
- Timing: strobes are registered. The strobe falls one cycle after ACQ entry. Total ARM+ACQ duration is exactly WINDOW cycles.
- Pending queue (1 deep): a command arriving when FSM != IDLE is stored.
  - If pending is already full, the new command overwrites it and dropped pulses (last wins).
  - A command arriving in the RELEASE cycle is stored first, then consumed by the same transition, so it runs next.
- Invariant: acquireWave and acquireFIR are never both 0.
- Width: the 19-bit counter never wraps, because it is cleared on every ARM entry. wavenum comparison is exact 16-bit inequality; wrap from 16'hFFFF to 0 counts as a change.

Test Plan:
1. Reset, send 'w' (CPB=1), wavenum changes 0→1 at 20 cycles after cmd_valid -> acquireWave=0 from ARM+21 until WINDOW cycles after ARM entry. acquireFIR stays 1. lastwavenum=1 after RELEASE.
2. Send 'i' with wavenum held at lastwavenum -> no strobe. timeout pulses at 36049 cycles after ARM entry. busy falls 2 cycles later.
3. Send 0x41 -> cmd_valid pulses with cmd_char=8'h41. busy stays 0.
4. Frame with stop bit 0 -> err_framing pulses once. cmd_char unchanged, no cmd_valid.
5. During ACQ for 'w', send 'i' then 'w' -> dropped pulses once. After RELEASE, ARM re-enters with kind WAVE. acquireFIR never goes low.
6. Assert rst while acquireFIR=0 -> acquireFIR=1 immediately (asynchronous), busy=0, pending cleared. With CLKS_PER_BIT=4, 'w' decodes correctly.
